// File: rtl/hamming_rx_deframer.sv
// Serial Hamming(7,4) receiver: collects 7-bit codewords, corrects
// single-bit errors and queues decoded nibbles in an output FIFO.
module hamming_rx_deframer #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_valid,
  input  logic             ser_bit,
  input  logic             ser_start,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_data,
  output logic             out_corr,
  output logic [CNT_W-1:0] corr_count,
  output logic             overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {
    IDLE,
    COLLECT
  } state_t;

  state_t     state;
  logic [2:0] idx;
  logic [6:0] code_buf;
  logic [6:0] hold;
  logic       pending;

  logic [4:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_n;
  logic [AW:0]   count;
  logic [AW:0]   count_rd;

  logic [2:0] syn;
  logic [6:0] mask;
  logic [6:0] fixed;
  logic [3:0] dec_data;
  logic       dec_corr;
  logic       full;
  logic       pop;
  logic       push_ok;

  always_comb begin
    syn[0] = hold[0] ^ hold[2] ^ hold[4] ^ hold[6];
    syn[1] = hold[1] ^ hold[2] ^ hold[5] ^ hold[6];
    syn[2] = hold[3] ^ hold[4] ^ hold[5] ^ hold[6];
    mask   = 7'b0;
    if (syn != 3'd0)
      mask[syn - 3'd1] = 1'b1;
    fixed    = hold ^ mask;
    dec_data = {fixed[6], fixed[5], fixed[4], fixed[2]};
    dec_corr = (syn != 3'd0);
  end

  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign pop      = out_valid && out_ready;
  assign push_ok  = pending && (!full || pop);
  assign rd_ptr_n = rd_ptr + AW'(pop);
  assign count_rd = count - (AW+1)'(pop);

  // A new start bit always wins, discarding any partial word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= 3'd0;
      code_buf <= 7'b0;
      hold     <= 7'b0;
      pending  <= 1'b0;
    end else begin
      pending <= 1'b0;
      if (ser_valid) begin
        if (ser_start) begin
          code_buf[0] <= ser_bit;
          idx         <= 3'd1;
          state       <= COLLECT;
        end else if (state == COLLECT) begin
          if (idx == 3'd6) begin
            hold    <= {ser_bit, code_buf[5:0]};
            pending <= 1'b1;
            state   <= IDLE;
            idx     <= 3'd0;
          end else begin
            code_buf[idx] <= ser_bit;
            idx           <= idx + 3'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= {dec_corr, dec_data};
  end

  // The head register only shows entries written before this edge,
  // so a freshly pushed word appears one cycle after the push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      out_valid  <= 1'b0;
      out_data   <= 4'b0;
      out_corr   <= 1'b0;
      corr_count <= '0;
      overflow   <= 1'b0;
    end else begin
      rd_ptr    <= rd_ptr_n;
      count     <= count_rd + (AW+1)'(push_ok);
      out_valid <= (count_rd != '0);
      if (count_rd != '0)
        {out_corr, out_data} <= mem[rd_ptr_n];
      if (push_ok)
        wr_ptr <= wr_ptr + AW'(1);
      if (pending && !push_ok)
        overflow <= 1'b1;
      if (push_ok && dec_corr && (corr_count != '1))
        corr_count <= corr_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hamming_rx_deframer.sv
// Scoreboard bench for hamming_rx_deframer: directed codewords,
// expected nibbles queued at issue, checked by a negedge monitor.
module tb_hamming_rx_deframer;

  logic       clk = 1'b0;
  logic       rst;
  logic       ser_valid;
  logic       ser_bit;
  logic       ser_start;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_corr;
  logic [7:0] corr_count;
  logic       overflow;

  int errors = 0;
  int checks = 0;
  logic [4:0] sb [$];

  hamming_rx_deframer #(
    .FIFO_DEPTH(4),
    .CNT_W(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ser_valid (ser_valid),
    .ser_bit   (ser_bit),
    .ser_start (ser_start),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_corr  (out_corr),
    .corr_count(corr_count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: got data=%b corr=%b expected none",
                 out_data, out_corr);
      end else begin
        logic [4:0] e;
        e = sb.pop_front();
        if ({out_corr, out_data} != e) begin
          errors++;
          $display("FAIL out_word: got data=%b corr=%b expected data=%b corr=%b",
                   out_data, out_corr, e[3:0], e[4]);
        end
      end
    end
  end

  task automatic send_range(input logic [6:0] code, input int lo,
                            input int hi, input logic with_start);
    for (int i = lo; i <= hi; i++) begin
      ser_valid = 1'b1;
      ser_bit   = code[i];
      ser_start = with_start && (i == lo);
      @(posedge clk);
      #1;
    end
    ser_valid = 1'b0;
    ser_start = 1'b0;
  endtask

  task automatic send_word(input logic [6:0] code, input logic [3:0] d,
                           input logic c, input logic expect_out);
    if (expect_out)
      sb.push_back({c, d});
    send_range(code, 0, 6, 1'b1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++)
      @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check("drain", sb.size(), 0);
  endtask

  typedef struct {
    logic [6:0] code;
    logic [3:0] d;
    logic       c;
  } vec_t;

  vec_t tbl [6];

  initial begin
    tbl[0] = '{7'b0000000, 4'b0000, 1'b0};
    tbl[1] = '{7'b1111111, 4'b1111, 1'b0};
    tbl[2] = '{7'b1111110, 4'b1111, 1'b1};
    tbl[3] = '{7'b0000100, 4'b0000, 1'b1};
    tbl[4] = '{7'b0110011, 4'b0110, 1'b0};
    tbl[5] = '{7'b1110011, 4'b0110, 1'b1};

    rst       = 1'b1;
    ser_valid = 1'b0;
    ser_bit   = 1'b0;
    ser_start = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_corr", out_corr, 0);
    check("rst_cnt", corr_count, 0);
    check("rst_ovf", overflow, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // clean word and latency
    send_word(7'b1010101, 4'b1011, 1'b0, 1'b1);
    @(negedge clk);
    check("lat_n0", out_valid, 0);
    @(negedge clk);
    check("lat_n1", out_valid, 0);
    @(negedge clk);
    check("lat_n2", out_valid, 1);
    wait_drain();
    check("cnt_clean", corr_count, 0);

    // position 5 flipped
    send_word(7'b1000101, 4'b1011, 1'b1, 1'b1);
    wait_drain();
    check("cnt_corr1", corr_count, 1);

    // partial word aborted by a new start
    send_range(7'b1111111, 0, 2, 1'b1);
    send_word(7'b1010101, 4'b1011, 1'b0, 1'b1);
    wait_drain();

    foreach (tbl[i])
      send_word(tbl[i].code, tbl[i].d, tbl[i].c, 1'b1);
    wait_drain();
    check("cnt_tbl", corr_count, 4);

    // fill the FIFO, fifth word dropped
    out_ready = 1'b0;
    send_word(7'b0110011, 4'b0110, 1'b0, 1'b1);
    send_word(7'b1010101, 4'b1011, 1'b0, 1'b1);
    send_word(7'b1111110, 4'b1111, 1'b1, 1'b1);
    send_word(7'b0000000, 4'b0000, 1'b0, 1'b1);
    send_word(7'b0000100, 4'b0000, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check("ovf_set", overflow, 1);
    check("ovf_cnt", corr_count, 5);
    check("hold_valid", out_valid, 1);
    check("hold_data", out_data, 4'b0110);
    check("hold_corr", out_corr, 0);
    out_ready = 1'b1;
    wait_drain();
    @(negedge clk);
    check("drained_valid", out_valid, 0);
    check("ovf_sticky", overflow, 1);

    // counter saturation
    for (int i = 0; i < 300; i++)
      send_word(7'b1000101, 4'b1011, 1'b1, 1'b1);
    wait_drain();
    check("cnt_sat", corr_count, 255);

    // reset mid-word
    send_range(7'b1010101, 0, 3, 1'b1);
    rst = 1'b1;
    #2;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_corr", out_corr, 0);
    check("mid_rst_cnt", corr_count, 0);
    check("mid_rst_ovf", overflow, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_range(7'b1010101, 4, 6, 1'b0);
    repeat (6) @(negedge clk);
    check("no_out_after_rst", out_valid, 0);
    check("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hamming_rx_deframer.md
HAMMING_RX_DEFRAMER -- requirements
Module: hamming_rx_deframer

Interface
REQ-001 SHALL provide parameter FIFO_DEPTH, default 4, output FIFO depth in entries (power of two, >=2).
REQ-002 SHALL provide parameter CNT_W, default 8, width of the corrected-word counter.
REQ-003 SHALL provide clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL provide rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL provide ser_valid  input  1  ser_bit/ser_start qualified this cycle.
REQ-006 SHALL provide ser_bit  input  1  serial codeword bit, code[0] first through code[6] last.
REQ-007 SHALL provide ser_start  input  1  marks the current bit as code[0] of a new codeword.
REQ-008 SHALL provide out_valid  output  1  FIFO head available.
REQ-009 SHALL provide out_ready  input  1  consumer accepts head when out_valid high.
REQ-010 SHALL provide out_data  output  4  corrected data nibble at FIFO head.
REQ-011 SHALL provide out_corr  output  1  head word had a single-bit error corrected.
REQ-012 SHALL provide corr_count  output  CNT_W  corrected words pushed, saturating.
REQ-013 SHALL provide overflow  output  1  sticky: a decoded word was dropped because the FIFO was full.

Function
REQ-014 Code mapping SHALL be: code[i] is Hamming position i+1; parity bits code[0], code[1], code[3]; data d[0]=code[2], d[1]=code[4], d[2]=code[5], d[3]=code[6].
REQ-015 Syndrome SHALL be s = {s4,s2,s1}: s1 = XOR of positions 1,3,5,7; s2 = XOR of 2,3,6,7; s4 = XOR of 4,5,6,7.
REQ-016 When s != 0, position s SHALL be inverted before data extraction and out_corr set for that word; when s == 0, out_corr = 0.
REQ-017 Collector FSM SHALL have states IDLE and COLLECT with a 3-bit bit index.
REQ-018 In IDLE, a bit with ser_valid=1 and ser_start=0 SHALL be ignored.
REQ-019 A bit with ser_valid=1 and ser_start=1, in either state, SHALL be stored as code[0], set index to 1 and enter COLLECT; any partial word is discarded.
REQ-020 In COLLECT, a bit with ser_valid=1 and ser_start=0 SHALL be stored at code[index] and index incremented; ser_valid=0 holds all state.
REQ-021 On acceptance of code[6], the full codeword SHALL be copied to a hold register, a pending flag set, and the FSM return to IDLE.
REQ-022 The collector SHALL be able to accept a new code[0] in the cycle immediately after code[6].
REQ-023 In the cycle after pending is set, the held word SHALL be decoded and pushed, and pending cleared.
REQ-024 Latency: with the FIFO empty, code[6] accepted at edge N SHALL give out_valid=1 after edge N+2.
REQ-025 A push SHALL succeed if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
REQ-026 Otherwise the word SHALL be dropped, overflow set until reset, and corr_count unchanged.
REQ-027 Pop SHALL occur when out_valid && out_ready; out_data and out_corr SHALL be stable while out_valid && !out_ready.
REQ-028 On an empty FIFO, simultaneous push and pop SHALL NOT bypass; out_valid rises the cycle after the push.
REQ-029 corr_count SHALL increment by 1 on each successful push with out_corr=1 and saturate at 2^CNT_W-1.
REQ-030 Uncorrectable double errors SHALL be miscorrected as the syndrome dictates; no detection is required.

Reset
REQ-031 rst high SHALL asynchronously force: FSM to IDLE, index 0, pending 0, FIFO empty, out_valid 0, out_data 0, out_corr 0, corr_count 0, overflow 0.
REQ-032 A reset mid-codeword or with pending set SHALL discard that word; collection after release requires a new ser_start.

Verification
REQ-033 Serial 7'b1010101 (code[0] first, start on the first bit) -> out_data 4'b1011, out_corr 0, corr_count 0, out_valid 2 cycles after the last bit.
REQ-034 Serial 7'b1000101 (position 5 flipped) -> out_data 4'b1011, out_corr 1, corr_count 1.
REQ-035 After 3 bits, ser_start with new word 7'b1010101 -> exactly one output, 4'b1011.
REQ-036 out_ready=0, 5 back-to-back words -> 4 held in order, overflow=1; then out_ready=1 drains 4 words, out_valid=0.
REQ-037 300 corrected words drained continuously -> corr_count saturates at 255.
REQ-038 rst pulsed after bit 4 of a word -> all outputs 0; the remaining bits without ser_start produce no output.
